// File: rtl/matrix_activation_engine_pkg.sv
// Shared definitions for the activation engine: memory-op encodings,
// activation mode codes, cfg-word field positions, descriptor offsets,
// the decoded cfg payload and the engine state encoding.
package matrix_activation_engine_pkg;

    localparam int unsigned ADDR_W = 32;

    // Memory controller request encodings
    localparam logic [1:0] MEM_OP_NONE  = 2'b00;
    localparam logic [1:0] MEM_OP_READ  = 2'b01;
    localparam logic [1:0] MEM_OP_WRITE = 2'b11;

    // Activation modes (code 3 is reserved and behaves as pass-through)
    localparam logic [1:0] ACT_MODE_PASS  = 2'd0;
    localparam logic [1:0] ACT_MODE_RELU  = 2'd1;
    localparam logic [1:0] ACT_MODE_LEAKY = 2'd2;
    localparam logic [1:0] ACT_MODE_RSVD  = 2'd3;

    // Negative-side slope of leaky ReLU is 1/8
    localparam int unsigned LEAKY_SHIFT = 3;

    // cfg word field positions
    localparam int unsigned CFG_SHIFT_LSB = 0;
    localparam int unsigned CFG_SHIFT_W   = 5;
    localparam int unsigned CFG_MODE_LSB  = 8;
    localparam int unsigned CFG_MODE_W    = 2;
    localparam int unsigned CFG_SAT8_BIT  = 12;

    // Job descriptor word offsets from BASE_ADDR
    localparam int unsigned DESC_N    = 0;
    localparam int unsigned DESC_CFG  = 1;
    localparam int unsigned DESC_DST  = 2;
    localparam int unsigned DESC_DATA = 3;

    typedef struct packed {
        logic                   sat8;
        logic [CFG_MODE_W-1:0]  mode;
        logic [CFG_SHIFT_W-1:0] shift;
    } act_cfg_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_N,
        S_RD_CFG,
        S_RD_DST,
        S_CHECK,
        S_RD_X,
        S_CALC,
        S_WR_Y,
        S_FIN
    } act_state_t;

endpackage

// File: rtl/matrix_activation_engine_act_datapath.sv
// act_datapath: combinational element transform y = sat8?(f_mode(x) >>> s).
// Ports: cfg (decoded mode/shift/sat8), x (signed input word),
//        y_c (signed result word, combinational).
module act_datapath
    import matrix_activation_engine_pkg::*;
#(
    parameter int unsigned TYPE_BW = 32
) (
    input  act_cfg_t           cfg,
    input  logic [TYPE_BW-1:0] x,
    output logic [TYPE_BW-1:0] y_c
);

    localparam logic signed [TYPE_BW-1:0] SAT_HI = TYPE_BW'(127);
    localparam logic signed [TYPE_BW-1:0] SAT_LO = TYPE_BW'(-128);

    logic signed [TYPE_BW-1:0] xs;
    logic signed [TYPE_BW-1:0] a;
    logic signed [TYPE_BW-1:0] b;

    // Shifts only shrink magnitude, so no intermediate overflow is possible
    always_comb begin
        xs = x;
        a  = xs;
        case (cfg.mode)
            ACT_MODE_RELU:  a = xs[TYPE_BW-1] ? '0 : xs;
            ACT_MODE_LEAKY: a = xs[TYPE_BW-1] ? (xs >>> LEAKY_SHIFT) : xs;
            ACT_MODE_PASS,
            ACT_MODE_RSVD:  a = xs;
            default:        a = xs;
        endcase
        b = a >>> cfg.shift;
        if (cfg.sat8 && (b > SAT_HI)) begin
            y_c = SAT_HI;
        end else if (cfg.sat8 && (b < SAT_LO)) begin
            y_c = SAT_LO;
        end else begin
            y_c = b;
        end
    end

endmodule

// File: rtl/matrix_activation_engine.sv
// matrix_activation_engine: reads a job descriptor and N input words from
// shared SRAM, applies ReLU/leaky-ReLU, arithmetic right shift and optional
// int8 saturation, and writes N results back. One memory request at a time.
// Ports: clk, reset (sync, active-low), enable/done (control unit handshake),
//        addr_o/data_o/mem_operation (request), data_i/mem_opdone (response).
// Optional: ACT_PERF_CNT_EN adds cycles_o, busy-cycle counter of the last job.
module matrix_activation_engine
    import matrix_activation_engine_pkg::*;
#(
    parameter int unsigned TYPE_BW   = 32,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned MAX_N     = 200
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    output logic               done,
    output logic [ADDR_W-1:0]  addr_o,
    input  logic [TYPE_BW-1:0] data_i,
    output logic [TYPE_BW-1:0] data_o,
    input  logic               mem_opdone,
    output logic [1:0]         mem_operation
`ifdef ACT_PERF_CNT_EN
    ,
    output logic [31:0]        cycles_o
`endif
);

    act_state_t         state_q;
    act_cfg_t           cfg_q;
    logic [TYPE_BW-1:0] n_q;
    logic [TYPE_BW-1:0] dst_q;
    logic [TYPE_BW-1:0] idx_q;
    logic [TYPE_BW-1:0] x_q;
    logic [TYPE_BW-1:0] y_c;
    logic [TYPE_BW-1:0] idx_nxt;
    logic               req_busy;
    logic               active;

    assign req_busy = (mem_operation != MEM_OP_NONE);
    assign active   = (state_q != S_IDLE) && (state_q != S_FIN);
    assign idx_nxt  = idx_q + TYPE_BW'(1);

    act_datapath #(.TYPE_BW(TYPE_BW)) u_datapath (
        .cfg (cfg_q),
        .x   (x_q),
        .y_c (y_c)
    );

    // Main FSM. A request is issued only when no request is outstanding;
    // completion clears mem_operation, so each new request is preceded by
    // at least one idle cycle after mem_opdone.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            done          <= 1'b0;
            addr_o        <= '0;
            data_o        <= '0;
            mem_operation <= MEM_OP_NONE;
            cfg_q         <= '0;
            n_q           <= '0;
            dst_q         <= '0;
            idx_q         <= '0;
            x_q           <= '0;
        end else if (active && !enable) begin
            // Abort takes priority over a simultaneous completion
            state_q       <= S_IDLE;
            done          <= 1'b0;
            mem_operation <= MEM_OP_NONE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done <= 1'b0;
                    if (enable) begin
                        state_q <= S_RD_N;
                    end
                end
                S_RD_N: begin
                    if (!req_busy) begin
                        mem_operation <= MEM_OP_READ;
                        addr_o        <= ADDR_W'(BASE_ADDR + DESC_N);
                    end else if (mem_opdone) begin
                        mem_operation <= MEM_OP_NONE;
                        n_q           <= data_i;
                        state_q       <= S_RD_CFG;
                    end
                end
                S_RD_CFG: begin
                    if (!req_busy) begin
                        mem_operation <= MEM_OP_READ;
                        addr_o        <= ADDR_W'(BASE_ADDR + DESC_CFG);
                    end else if (mem_opdone) begin
                        mem_operation <= MEM_OP_NONE;
                        cfg_q.shift   <= data_i[CFG_SHIFT_LSB +: CFG_SHIFT_W];
                        cfg_q.mode    <= data_i[CFG_MODE_LSB +: CFG_MODE_W];
                        cfg_q.sat8    <= data_i[CFG_SAT8_BIT];
                        state_q       <= S_RD_DST;
                    end
                end
                S_RD_DST: begin
                    if (!req_busy) begin
                        mem_operation <= MEM_OP_READ;
                        addr_o        <= ADDR_W'(BASE_ADDR + DESC_DST);
                    end else if (mem_opdone) begin
                        mem_operation <= MEM_OP_NONE;
                        dst_q         <= data_i;
                        state_q       <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if ((n_q == '0) || (n_q > TYPE_BW'(MAX_N))) begin
                        done    <= 1'b1;
                        state_q <= S_FIN;
                    end else begin
                        idx_q   <= '0;
                        state_q <= S_RD_X;
                    end
                end
                S_RD_X: begin
                    if (!req_busy) begin
                        mem_operation <= MEM_OP_READ;
                        addr_o        <= ADDR_W'(BASE_ADDR + DESC_DATA) + ADDR_W'(idx_q);
                    end else if (mem_opdone) begin
                        mem_operation <= MEM_OP_NONE;
                        x_q           <= data_i;
                        state_q       <= S_CALC;
                    end
                end
                S_CALC: begin
                    data_o  <= y_c;
                    state_q <= S_WR_Y;
                end
                S_WR_Y: begin
                    if (!req_busy) begin
                        mem_operation <= MEM_OP_WRITE;
                        addr_o        <= ADDR_W'(dst_q) + ADDR_W'(idx_q);
                    end else if (mem_opdone) begin
                        mem_operation <= MEM_OP_NONE;
                        idx_q         <= idx_nxt;
                        if (idx_nxt == n_q) begin
                            done    <= 1'b1;
                            state_q <= S_FIN;
                        end else begin
                            state_q <= S_RD_X;
                        end
                    end
                end
                S_FIN: begin
                    if (!enable) begin
                        done    <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        done <= 1'b1;
                    end
                end
                default: begin
                    state_q       <= S_IDLE;
                    mem_operation <= MEM_OP_NONE;
                end
            endcase
        end
    end

`ifdef ACT_PERF_CNT_EN
    // Busy-cycle counter: cleared on start, counts every non-IDLE/FIN cycle
    always_ff @(posedge clk) begin
        if (!reset) begin
            cycles_o <= '0;
        end else if ((state_q == S_IDLE) && enable) begin
            cycles_o <= '0;
        end else if (active && (cycles_o != 32'hFFFF_FFFF)) begin
            cycles_o <= cycles_o + 32'd1;
        end
    end
`endif

endmodule
